mem_port_initiator: RTL and testbench

Single-clock initiator that drives one port (A or B) of `dual_port_multi_bank_memory` from a valid/ready request stream. It issues writes and reads on the memory's en/we/addr/din interface and absorbs the memory's 1-cycle read latency. Read data returns on a valid/ready response stream through a credit-protected FIFO, so no read result is ever dropped under back-pressure. It sits between a client (DMA, CPU bridge, test driver) and one memory port.

---
 rtl/mem_port_pkg.sv | 12 +
 rtl/rsp_fifo.sv | 53 +++++
 rtl/mem_port_initiator.sv | 101 ++++++++++
 tb/tb_mem_port_initiator.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared widths and the response payload carried through the initiator's read-return FIFO.
package mem_port_pkg;

  localparam int unsigned MEM_WIDTH      = 8;
  localparam int unsigned MEM_ADDR_TOTAL = 10;

  typedef struct packed {
    logic [MEM_ADDR_TOTAL-1:0] addr;
    logic [MEM_WIDTH-1:0]      data;
  } rsp_entry_t;

endpackage

// File: rtl/rsp_fifo.sv
// First-word-fall-through response FIFO; the head is read straight from storage.
module rsp_fifo
  import mem_port_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  rsp_entry_t       i_push_data,
  input  logic             i_pop,
  output rsp_entry_t       o_head,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rsp_entry_t       store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;

  assign do_pop = i_pop & (count != '0);

  always_ff @(posedge i_clk) begin
    if (i_push) store[wr_ptr] <= i_push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({i_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign o_head  = store[rd_ptr];
  assign o_empty = (count == '0);
  assign o_count = count;

endmodule

// File: rtl/mem_port_initiator.sv
// Drives one memory port from a request stream; read data returns through a credit-protected FIFO.
module mem_port_initiator
  import mem_port_pkg::*;
#(
  parameter int unsigned WIDTH      = MEM_WIDTH,
  parameter int unsigned ADDR_TOTAL = MEM_ADDR_TOTAL,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_TOTAL-1:0] i_req_addr,
  input  logic [WIDTH-1:0]      i_req_din,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_TOTAL-1:0] o_mem_addr,
  output logic [WIDTH-1:0]      o_mem_din,
  input  logic [WIDTH-1:0]      i_mem_dout,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WIDTH-1:0]      o_rsp_data,
  output logic [ADDR_TOTAL-1:0] o_rsp_addr,
  output logic                  o_busy
);

  localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned USED_W = CNT_W + 1;

  logic                  accept;
  logic                  s1_rd;
  logic                  s2_rd;
  logic [ADDR_TOTAL-1:0] s2_addr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  pop;
  logic [USED_W-1:0]     used;
  rsp_entry_t            push_entry;
  rsp_entry_t            head;

  // Every read in S1/S2 already owns a FIFO slot, so a push never meets a full FIFO.
  assign s1_rd       = o_mem_en & ~o_mem_we;
  assign used        = USED_W'(fifo_count) + USED_W'(s1_rd) + USED_W'(s2_rd);
  assign o_req_ready = (used < USED_W'(RSP_DEPTH)) & i_rst_n;
  assign accept      = i_req_valid & o_req_ready;

  // Issue stage: registered memory command; addr/din hold when idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mem_en   <= 1'b0;
      o_mem_we   <= 1'b0;
      o_mem_addr <= '0;
      o_mem_din  <= '0;
    end else begin
      o_mem_en <= accept;
      o_mem_we <= accept & i_req_we;
      if (accept) begin
        o_mem_addr <= i_req_addr;
        o_mem_din  <= i_req_din;
      end
    end
  end

  // Return stage: tracks the read whose data the memory presents this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_rd   <= 1'b0;
      s2_addr <= '0;
    end else begin
      s2_rd <= s1_rd;
      if (s1_rd) s2_addr <= o_mem_addr;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.addr = MEM_ADDR_TOTAL'(s2_addr);
    push_entry.data = MEM_WIDTH'(i_mem_dout);
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (s2_rd),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_head      (head),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  assign o_rsp_valid = ~fifo_empty;
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign o_rsp_data  = fifo_empty ? '0 : WIDTH'(head.data);
  assign o_rsp_addr  = fifo_empty ? '0 : ADDR_TOTAL'(head.addr);
  assign o_busy      = s1_rd | s2_rd | ~fifo_empty;

endmodule

// File: tb/tb_mem_port_initiator.sv
// Directed bench for mem_port_initiator with a behavioural memory and a response scoreboard.
module tb_mem_port_initiator;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_we;
  logic [9:0] i_req_addr;
  logic [7:0] i_req_din;
  logic       o_mem_en;
  logic       o_mem_we;
  logic [9:0] o_mem_addr;
  logic [7:0] o_mem_din;
  logic [7:0] i_mem_dout;
  logic       o_rsp_valid;
  logic       i_rsp_ready;
  logic [7:0] o_rsp_data;
  logic [9:0] o_rsp_addr;
  logic       o_busy;

  mem_port_initiator dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_din   (i_req_din),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_din   (o_mem_din),
    .i_mem_dout  (i_mem_dout),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_addr  (o_rsp_addr),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Memory port with one cycle read latency.
  logic [7:0] mem [1024];
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_din;
      else          i_mem_dout      <= mem[o_mem_addr];
    end
  end

  int cyc;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard and logs, sampled on the falling edge.
  logic [7:0]  ref_mem [1024];
  logic [17:0] exp_q[$];
  logic [9:0]  pop_addr[$];
  logic [7:0]  pop_data[$];
  int          pop_cyc[$];
  int          rd_acc[$];

  initial forever begin
    @(negedge i_clk);
    if (i_rst_n && i_req_valid && o_req_ready) begin
      if (i_req_we) ref_mem[i_req_addr] = i_req_din;
      else begin
        exp_q.push_back({i_req_addr, ref_mem[i_req_addr]});
        rd_acc.push_back(cyc + 1);
      end
    end
    if (o_rsp_valid && i_rsp_ready) begin
      pop_addr.push_back(o_rsp_addr);
      pop_data.push_back(o_rsp_data);
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("scb_extra", 64'd1, 64'd0);
      else check("scb", {46'd0, o_rsp_addr, o_rsp_data}, {46'd0, exp_q.pop_front()});
    end
  end

  task automatic clear_logs();
    pop_addr.delete();
    pop_data.delete();
    pop_cyc.delete();
    rd_acc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Holds a request until accepted; called just after a rising edge.
  task automatic send(input logic we, input logic [9:0] addr, input logic [7:0] din);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_din   = din;
    while (!acc && n < 50) begin
      @(negedge i_clk);
      acc = o_req_ready;
      @(posedge i_clk);
      #1;
      n++;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    i_req_valid = 1'b0;
  endtask

  // Idle cycles with the memory command checked quiet.
  task automatic gap(input int n);
    @(posedge i_clk);
    #1;
    repeat (n) begin
      @(negedge i_clk);
      check("gap_en", 64'(o_mem_en), 64'd0);
      check("gap_we", 64'(o_mem_we), 64'd0);
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic check_pop(input string tag, input int idx, input logic [9:0] a, input logic [7:0] d);
    if (idx < pop_addr.size()) begin
      check({tag, "_addr"}, 64'(pop_addr[idx]), 64'(a));
      check({tag, "_data"}, 64'(pop_data[idx]), 64'(d));
    end
  endtask

  logic [9:0] t1_addr [4] = '{10'd312, 10'd202, 10'd101, 10'd10};
  logic [7:0] t1_data [4] = '{8'd12, 8'd22, 8'd23, 8'd98};
  logic [9:0] bp_addr [6] = '{10'd312, 10'd202, 10'd101, 10'd10, 10'd312, 10'd202};
  logic [7:0] bp_data [6] = '{8'd12, 8'd22, 8'd23, 8'd98, 8'd12, 8'd22};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   k;
    logic acc;
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_din   = '0;
    i_rsp_ready = 1'b1;
    #23;
    check("reset_outs", {23'd0, o_req_ready, o_rsp_valid, o_busy, o_mem_en, o_mem_we,
                         o_mem_addr, o_mem_din, o_rsp_data, o_rsp_addr}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    check("reset_ready", 64'(o_req_ready), 64'd1);
    @(posedge i_clk);
    #1;

    // Write then read back.
    clear_logs();
    send(1'b1, 10'd312, 8'd12);
    send(1'b1, 10'd202, 8'd22);
    send(1'b1, 10'd10,  8'd98);
    send(1'b1, 10'd101, 8'd23);
    for (int i = 0; i < 4; i++) send(1'b0, t1_addr[i], 8'd0);
    idle(6);
    check("t1_count", 64'(pop_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_pop("t1", i, t1_addr[i], t1_data[i]);
    if (pop_cyc.size() == 4 && rd_acc.size() == 4) begin
      check("t1_latency", 64'(pop_cyc[0] - rd_acc[0]), 64'd2);
      check("t1_stream", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
    end

    // Back-pressure: only RSP_DEPTH reads get credits.
    clear_logs();
    i_rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      i_req_valid = (k < 6);
      i_req_we    = 1'b0;
      i_req_addr  = bp_addr[k % 6];
      @(negedge i_clk);
      acc = i_req_valid && o_req_ready;
      @(posedge i_clk);
      #1;
      if (acc) k++;
    end
    check("bp_accepted", 64'(k), 64'd4);
    check("bp_ready_low", 64'(o_req_ready), 64'd0);
    check("bp_valid", 64'(o_rsp_valid), 64'd1);
    check("bp_no_pop", 64'(pop_addr.size()), 64'd0);
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 20 && k < 6; c++) begin
      i_req_valid = 1'b1;
      i_req_addr  = bp_addr[k % 6];
      @(negedge i_clk);
      acc = o_req_ready;
      @(posedge i_clk);
      #1;
      if (acc) k++;
    end
    i_req_valid = 1'b0;
    check("bp_total", 64'(k), 64'd6);
    idle(8);
    check("bp_count", 64'(pop_addr.size()), 64'd6);
    for (int i = 0; i < 6; i++) check_pop("bp", i, bp_addr[i], bp_data[i]);
    if (rd_acc.size() == 6 && pop_cyc.size() > 0)
      check("bp_late_accept", 64'(rd_acc[4] > pop_cyc[0]), 64'd1);

    // Write/read hazard on consecutive cycles.
    clear_logs();
    send(1'b1, 10'd5, 8'd77);
    send(1'b0, 10'd5, 8'd0);
    idle(5);
    check("haz_count", 64'(pop_addr.size()), 64'd1);
    check_pop("haz", 0, 10'd5, 8'd77);

    // Idle and interleave.
    clear_logs();
    send(1'b1, 10'd600, 8'd40);
    gap(2);
    send(1'b0, 10'd600, 8'd0);
    gap(1);
    send(1'b1, 10'd601, 8'd41);
    gap(3);
    send(1'b0, 10'd601, 8'd0);
    check("il_busy_hi", 64'(o_busy), 64'd1);
    gap(2);
    idle(4);
    check("il_count", 64'(pop_addr.size()), 64'd2);
    check_pop("il0", 0, 10'd600, 8'd40);
    check_pop("il1", 1, 10'd601, 8'd41);
    check("il_busy_lo", 64'(o_busy), 64'd0);

    // Reset with 3 queued and 1 read in S2.
    clear_logs();
    i_rsp_ready = 1'b0;
    send(1'b0, 10'd312, 8'd0);
    send(1'b0, 10'd202, 8'd0);
    send(1'b0, 10'd101, 8'd0);
    send(1'b0, 10'd10,  8'd0);
    idle(1);
    check("pre_rst_count", 64'(dut.u_fifo.o_count), 64'd3);
    i_rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_outs", {23'd0, o_req_ready, o_rsp_valid, o_busy, o_mem_en, o_mem_we,
                           o_mem_addr, o_mem_din, o_rsp_data, o_rsp_addr}, 64'd0);
    idle(2);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_rsp_ready = 1'b1;
    #1;
    check("post_rst_valid", 64'(o_rsp_valid), 64'd0);
    check("post_rst_ready", 64'(o_req_ready), 64'd1);
    @(posedge i_clk);
    #1;
    clear_logs();
    send(1'b0, 10'd10, 8'd0);
    idle(5);
    check("post_rst_count", 64'(pop_addr.size()), 64'd1);
    check_pop("post_rst", 0, 10'd10, 8'd98);

    // Streaming reads with simultaneous push/pop.
    for (int i = 0; i < 16; i++) send(1'b1, 10'(700 + i), 8'(3 * i + 1));
    idle(2);
    clear_logs();
    fork
      begin
        for (int i = 0; i < 16; i++) send(1'b0, 10'(700 + i), 8'd0);
      end
      begin
        repeat (3) @(posedge i_clk);
        repeat (10) begin
          @(negedge i_clk);
          check("pp_fifo_count", 64'(dut.u_fifo.o_count), 64'd1);
        end
      end
    join
    idle(6);
    check("pp_count", 64'(pop_addr.size()), 64'd16);
    for (int i = 0; i < 16; i++) check_pop("pp", i, 10'(700 + i), 8'(3 * i + 1));
    if (rd_acc.size() == 16) check("pp_throughput", 64'(rd_acc[15] - rd_acc[0]), 64'd15);
    check("scb_drained", 64'(exp_q.size()), 64'd0);
    check("final_busy", 64'(o_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
